win_judge: RTL and testbench

- Sits directly downstream of the keypad board-state stage and alongside the VGA renderer.
- Consumes the 18-bit board vector `state_flat` (9 cells x 2 bits, cell 0 in bits [1:0]) and detects three-in-a-row for either player.
- Latches the winner, keeps per-player score counters and drives the two seven-segment digits.
- Holds the result for a programmable time, then issues a one-cycle board-clear request and re-arms once the board reads empty.

---
 rtl/win_judge.sv | 181 ++++++++++++++++++
 tb/tb_win_judge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_judge.sv
`default_nettype none
// win_judge: three-in-a-row judge with score counters, result hold, board-clear pulse and score digits.
// Optional build macro DRAW_DETECT_EN adds full-board draw detection (winner = 3).  Rev 1.0
module win_judge #(
   parameter int HOLD_CYCLES = 500,
   parameter int SCORE_MAX   = 9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [17:0] state_flat,
   output logic [1:0]  winner,
   output logic        gameOver,
   output logic [7:0]  winLine,
   output logic        clearBoard,
   output logic [3:0]  scoreX,
   output logic [3:0]  scoreO,
   output logic [6:0]  sevenDisplayOne,
   output logic [6:0]  sevenDisplayTwo
);
   localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [3:0]       SCORE_TOP = 4'(SCORE_MAX);
   localparam logic [6:0]       SEG_ZERO  = 7'b1000000;

   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      WIN        = 2'd1,
      CLEAR      = 2'd2,
      WAIT_EMPTY = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] hold_cnt, hold_nx;
   logic [7:0]       hit_x, hit_o;
   logic [1:0]       winner_nx;
   logic [7:0]       line_nx;
   logic             over_nx;
   logic [3:0]       sx_nx, so_nx;
`ifdef DRAW_DETECT_EN
   logic             full_q;
`endif

   // Bitmap order: rows 0-2, columns 0-2, main diagonal, anti-diagonal.
   function automatic logic [7:0] lines_for(input logic [17:0] b, input logic [1:0] p);
      logic [8:0] m;
      logic [7:0] l;
      for (int i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == p);
      l[0] = m[0] & m[1] & m[2];
      l[1] = m[3] & m[4] & m[5];
      l[2] = m[6] & m[7] & m[8];
      l[3] = m[0] & m[3] & m[6];
      l[4] = m[1] & m[4] & m[7];
      l[5] = m[2] & m[5] & m[8];
      l[6] = m[0] & m[4] & m[8];
      l[7] = m[2] & m[4] & m[6];
      return l;
   endfunction

`ifdef DRAW_DETECT_EN
   // Code 3 counts as empty, so only 1 and 2 occupy a cell.
   function automatic logic board_full(input logic [17:0] b);
      logic f;
      f = 1'b1;
      for (int i = 0; i < 9; i++) f = f & ((b[2*i +: 2] == 2'd1) | (b[2*i +: 2] == 2'd2));
      return f;
   endfunction
`endif

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   function automatic logic [3:0] bump(input logic [3:0] s);
      return (s == SCORE_TOP) ? 4'd0 : 4'(s + 4'd1);
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= PLAY;
         hold_cnt        <= '0;
         hit_x           <= '0;
         hit_o           <= '0;
         winner          <= 2'd0;
         winLine         <= 8'd0;
         gameOver        <= 1'b0;
         scoreX          <= 4'd0;
         scoreO          <= 4'd0;
         sevenDisplayOne <= SEG_ZERO;
         sevenDisplayTwo <= SEG_ZERO;
`ifdef DRAW_DETECT_EN
         full_q          <= 1'b0;
`endif
      end else begin
         state           <= state_nx;
         hold_cnt        <= hold_nx;
         hit_x           <= lines_for(state_flat, 2'd2);
         hit_o           <= lines_for(state_flat, 2'd1);
         winner          <= winner_nx;
         winLine         <= line_nx;
         gameOver        <= over_nx;
         scoreX          <= sx_nx;
         scoreO          <= so_nx;
         // Digits follow the score registers one edge later.
         sevenDisplayOne <= seg7(scoreX);
         sevenDisplayTwo <= seg7(scoreO);
`ifdef DRAW_DETECT_EN
         full_q          <= board_full(state_flat);
`endif
      end
   end

   always_comb begin
      state_nx  = state;
      hold_nx   = hold_cnt;
      winner_nx = winner;
      line_nx   = winLine;
      over_nx   = gameOver;
      sx_nx     = scoreX;
      so_nx     = scoreO;
      case (state)
         PLAY: begin
            // Cross wins ties: it is checked first and only its score moves.
            if (|hit_x) begin
               winner_nx = 2'd2;
               line_nx   = hit_x;
               over_nx   = 1'b1;
               sx_nx     = bump(scoreX);
               state_nx  = WIN;
            end else if (|hit_o) begin
               winner_nx = 2'd1;
               line_nx   = hit_o;
               over_nx   = 1'b1;
               so_nx     = bump(scoreO);
               state_nx  = WIN;
            end
`ifdef DRAW_DETECT_EN
            else if (full_q) begin
               winner_nx = 2'd3;
               line_nx   = 8'd0;
               over_nx   = 1'b1;
               state_nx  = WIN;
            end
`endif
         end
         WIN: begin
            if (hold_cnt == HOLD_LAST) begin
               hold_nx  = '0;
               state_nx = CLEAR;
            end else begin
               hold_nx  = hold_cnt + CNT_W'(1);
            end
         end
         CLEAR: state_nx = WAIT_EMPTY;
         WAIT_EMPTY: begin
            if (state_flat == 18'd0) begin
               state_nx  = PLAY;
               winner_nx = 2'd0;
               line_nx   = 8'd0;
               over_nx   = 1'b0;
            end
         end
         default: state_nx = PLAY;
      endcase
   end

   assign clearBoard = (state == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_win_judge.sv
`default_nettype none
// tb_win_judge: directed literal checks plus randomized boards against a game-level reference model.
module tb_win_judge;
   localparam int HOLD = 4;
   localparam int SMAX = 9;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [17:0] state_flat = 18'd0;
   logic [1:0]  winner;
   logic        gameOver;
   logic [7:0]  winLine;
   logic        clearBoard;
   logic [3:0]  scoreX, scoreO;
   logic [6:0]  sevenDisplayOne, sevenDisplayTwo;

   win_judge #(.HOLD_CYCLES(HOLD), .SCORE_MAX(SMAX)) dut (
      .clock(clock), .reset(reset), .state_flat(state_flat),
      .winner(winner), .gameOver(gameOver), .winLine(winLine), .clearBoard(clearBoard),
      .scoreX(scoreX), .scoreO(scoreO),
      .sevenDisplayOne(sevenDisplayOne), .sevenDisplayTwo(sevenDisplayTwo)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   bit go       = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic logic [7:0] lines_of(input logic [17:0] b, input logic [1:0] p);
      logic [7:0] r;
      r = 8'd0;
      for (int l = 0; l < 8; l++) begin
         bit all;
         all = 1'b1;
         for (int k = 0; k < 3; k++) if (b[2*LN[l][k] +: 2] != p) all = 1'b0;
         r[l] = all;
      end
      return r;
   endfunction

   function automatic bit is_full(input logic [17:0] b);
      for (int i = 0; i < 9; i++) if (b[2*i +: 2] == 2'd0 || b[2*i +: 2] == 2'd3) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [6:0] seg_of(input int v);
      logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return (v >= 0 && v <= 9) ? tbl[v] : 7'h7F;
   endfunction

   logic [1:0]  m_winner;
   logic [7:0]  m_line;
   logic        m_over, m_clear;
   int          m_sx, m_so;
   logic [6:0]  m_seg1, m_seg2;
   logic [17:0] seen_board;   // board sampled on the previous edge
   bit          armed;
   int          n, win_edge;

   // The game is tracked as edge numbers: a win recorded at edge W clears at W+HOLD
   // and can re-arm on any empty board from edge W+HOLD+2 onward.
   initial begin
      n = 0;
      forever begin
         @(posedge clock);
         n++;
         if (reset) begin
            m_winner = 0; m_line = 0; m_over = 0; m_clear = 0;
            m_sx = 0; m_so = 0; m_seg1 = 7'h40; m_seg2 = 7'h40;
            armed = 1'b1; win_edge = 0; seen_board = 18'd0;
         end else begin
            logic [7:0] xl, ol;
            m_seg1 = seg_of(m_sx);
            m_seg2 = seg_of(m_so);
            m_clear = 1'b0;
            xl = lines_of(seen_board, 2'd2);
            ol = lines_of(seen_board, 2'd1);
            if (armed) begin
               if (xl != 0) begin
                  m_winner = 2; m_line = xl; m_over = 1; armed = 0; win_edge = n;
                  m_sx = (m_sx + 1) % (SMAX + 1);
               end else if (ol != 0) begin
                  m_winner = 1; m_line = ol; m_over = 1; armed = 0; win_edge = n;
                  m_so = (m_so + 1) % (SMAX + 1);
               end
`ifdef DRAW_DETECT_EN
               else if (is_full(seen_board)) begin
                  m_winner = 3; m_line = 0; m_over = 1; armed = 0; win_edge = n;
               end
`endif
            end else if (n == win_edge + HOLD) begin
               m_clear = 1'b1;
            end else if (n >= win_edge + HOLD + 2 && state_flat == 18'd0) begin
               m_winner = 0; m_line = 0; m_over = 0; armed = 1'b1;
            end
            seen_board = state_flat;
         end
      end
   end

   always @(negedge clock) begin
      if (go) begin
         check("winner",     32'(winner),          32'(m_winner));
         check("winLine",    32'(winLine),         32'(m_line));
         check("gameOver",   32'(gameOver),        32'(m_over));
         check("clearBoard", 32'(clearBoard),      32'(m_clear));
         check("scoreX",     32'(scoreX),          32'(m_sx));
         check("scoreO",     32'(scoreO),          32'(m_so));
         check("segOne",     32'(sevenDisplayOne), 32'(m_seg1));
         check("segTwo",     32'(sevenDisplayTwo), 32'(m_seg2));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int k = 1);
      repeat (k) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic finish_game();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < HOLD + 8 && !seen; k++) begin
         step(1);
         if (clearBoard) seen = 1'b1;
      end
      check("clear_seen", 32'(seen), 32'd1);
      step(1);
      state_flat = 18'd0;
      step(2);
      check("rearm_gameOver", 32'(gameOver), 32'd0);
   endtask

   initial begin
      logic [17:0] b;
      step(1);
      go = 1'b1;
      step(2);
      reset = 1'b0;
      step(3);
      check("rst_winner", 32'(winner), 32'd0);
      check("rst_over",   32'(gameOver), 32'd0);
      check("rst_scores", {24'd0, scoreX, scoreO}, 32'd0);
      check("rst_seg1",   32'(sevenDisplayOne), 32'h40);
      check("rst_seg2",   32'(sevenDisplayTwo), 32'h40);
      check("rst_clear",  32'(clearBoard), 32'd0);

      // Top row X.
      state_flat = 18'h0002A;
      step(2);
      check("row_winner", 32'(winner), 32'd2);
      check("row_line",   32'(winLine), 32'h01);
      check("row_over",   32'(gameOver), 32'd1);
      check("row_scoreX", 32'(scoreX), 32'd1);
      step(1);
      check("row_seg1",   32'(sevenDisplayOne), 32'h79);
      step(2);
      check("hold_noclear", 32'(clearBoard), 32'd0);
      step(1);
      check("hold_clear",   32'(clearBoard), 32'd1);
      step(1);
      check("clear_once",   32'(clearBoard), 32'd0);
      check("wait_over",    32'(gameOver), 32'd1);
      step(3);
      check("wait_still",   32'(gameOver), 32'd1);
      state_flat = 18'd0;
      step(1);
      check("empty_over",   32'(gameOver), 32'd0);
      check("empty_winner", 32'(winner), 32'd0);

      // O on the anti-diagonal.
      state_flat = 18'h01110;
      step(2);
      check("anti_winner", 32'(winner), 32'd1);
      check("anti_line",   32'(winLine), 32'h80);
      check("anti_scoreO", 32'(scoreO), 32'd1);
      finish_game();

      // X on column 0 and the main diagonal at once.
      state_flat = 18'h22282;
      step(2);
      check("dual_line",   32'(winLine), 32'h48);
      check("dual_scoreX", 32'(scoreX), 32'd2);
      finish_game();

      // Full board with no line.
      state_flat = 18'h295A6;
      step(2);
`ifdef DRAW_DETECT_EN
      check("draw_winner", 32'(winner), 32'd3);
      check("draw_line",   32'(winLine), 32'd0);
      check("draw_scores", {24'd0, scoreX, scoreO}, 32'h21);
      finish_game();
`else
      check("full_winner", 32'(winner), 32'd0);
      check("full_over",   32'(gameOver), 32'd0);
      step(6);
      check("full_clear",  32'(clearBoard), 32'd0);
      state_flat = 18'd0;
      step(2);
`endif

      // Reset in the middle of the hold.
      state_flat = 18'h0002A;
      step(3);
      reset = 1'b1;
      step(1);
      check("midrst_over",  32'(gameOver), 32'd0);
      check("midrst_score", {24'd0, scoreX, scoreO}, 32'd0);
      state_flat = 18'd0;
      reset = 1'b0;
      for (int k = 0; k < HOLD + 4; k++) begin
         step(1);
         check("midrst_noclear", 32'(clearBoard), 32'd0);
      end

      // Ten X wins: score runs 1..9 then wraps to 0.
      for (int i = 1; i <= 10; i++) begin
         state_flat = 18'h0002A;
         step(2);
         check("wrap_scoreX", 32'(scoreX), 32'(i % 10));
         finish_game();
      end
      check("wrap_seg1", 32'(sevenDisplayOne), 32'h40);

      // Randomized boards with occasional resets.
      b = 18'd0;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 4) == 0) begin
            b = 18'd0;
         end else if ($urandom_range(0, 2) != 0) begin
            for (int k = 0; k < 9; k++)
               b[2*k +: 2] = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         end
         state_flat = b;
         step(1);
      end
      reset = 1'b0;
      state_flat = 18'd0;
      step(2);
      go = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
